// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// followed by a sign-fix cycle. start/done handshake; busy covers CALC and FIX.
`timescale 1ns/1ps
module signed_divider #(
  parameter int DW = 10,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);

  // Handshake: start is accepted only in IDLE or DONE (busy=0); while busy it is ignored.
  // done is a one-cycle pulse in DONE, and results stay valid until the next FIX or dbz accept.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  nmag;      // |N| shifts out MSB-first while quotient bits shift in
  logic [VW-1:0]  dmag;
  logic [VW:0]    prem;
  logic [CW-1:0]  cnt;
  logic           sn, sd;
  logic           accept, div0, last_step, qbit;
  logic [VW+1:0]  trial, diff;

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    div0      = (divisor == '0);
    last_step = (cnt == CW'(DW - 1));
    trial     = {prem, nmag[DW-1]};
    diff      = trial - {2'b00, dmag};
    qbit      = ~diff[VW+1];
    state_nx  = state;
    case (state)
      IDLE:    if (accept) state_nx = div0 ? DONE : CALC;
      CALC:    if (last_step) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = accept ? (div0 ? DONE : CALC) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmag      <= '0;
      dmag      <= '0;
      prem      <= '0;
      cnt       <= '0;
      sn        <= 1'b0;
      sd        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept && !div0) begin
      nmag <= dividend[DW-1] ? -dividend : dividend;
      dmag <= divisor[VW-1] ? -divisor : divisor;
      sn   <= dividend[DW-1];
      sd   <= divisor[VW-1];
      prem <= '0;
      cnt  <= '0;
    end else if (accept) begin
      quotient  <= '1;
      remainder <= '0;
      dbz       <= 1'b1;
      ovf       <= 1'b0;
    end else if (state == CALC) begin
      prem <= qbit ? diff[VW:0] : trial[VW:0];
      nmag <= {nmag[DW-2:0], qbit};
      cnt  <= cnt + CW'(1);
    end else if (state == FIX) begin
      quotient  <= (sn ^ sd) ? -nmag : nmag;
      remainder <= sn ? -prem[VW-1:0] : prem[VW-1:0];
      dbz       <= 1'b0;
      // Only -2^(DW-1) / -1 yields a positive magnitude with the MSB set.
      ovf       <= nmag[DW-1] & ~(sn ^ sd);
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_signed_divider.sv
// Randomized and directed bench for signed_divider: a driver issues divisions, a monitor
// pops the expected results from a queue whenever done pulses.
`timescale 1ns/1ps
module tb_signed_divider;
  localparam int DW = 10;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy, done, dbz, ovf;

  signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .dbz(dbz), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Entry layout: {n[31:22], d[21:17], q[16:7], r[6:2], dbz[1], ovf[0]}
  logic [31:0] exp_q[$];
  int          issue_q[$];
  logic [DW+VW+1:0] hold_v = '0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign.
  function automatic logic [31:0] model(int n, int d);
    int q, r;
    logic dz, ov;
    dz = 1'b0;
    ov = 1'b0;
    if (d == 0) begin
      q = -1; r = 0; dz = 1'b1;
    end else if (n == -(1 << (DW - 1)) && d == -1) begin
      q = n; r = 0; ov = 1'b1;
    end else begin
      q = n / d; r = n % d;
    end
    return {DW'(n), VW'(d), DW'(q), VW'(r), dz, ov};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(int n, int d, bit expect_result);
    start    = 1'b1;
    dividend = DW'(n);
    divisor  = VW'(d);
    if (expect_result) begin
      exp_q.push_back(model(n, d));
      issue_q.push_back(cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(int n, int d);
    issue(n, d, 1'b1);
    wait_done();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int t0, ni, di, qi, ri, lat;
    if (!rst_n) begin
      hold_v = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        t0 = issue_q.pop_front();
        ni = int'($signed(e[31:22]));
        di = int'($signed(e[21:17]));
        lat = (di == 0) ? 1 : DW + 2;
        chk($sformatf("latency N=%0d D=%0d", ni, di), 32'(cyc - t0), 32'(lat));
        chk($sformatf("result{q,r,dbz,ovf} N=%0d D=%0d", ni, di),
            32'({quotient, remainder, dbz, ovf}), 32'(e[16:0]));
        if (!dbz && !ovf) begin
          qi = int'($signed(quotient));
          ri = int'($signed(remainder));
          chk($sformatf("invariant N=%0d D=%0d", ni, di),
              32'((qi * di + ri == ni) && ((ri < 0 ? -ri : ri) < (di < 0 ? -di : di)) &&
                  (ri == 0 || ((ri < 0) == (ni < 0)))), 32'd1);
        end
        hold_v = e[16:0];
      end
    end else if (busy) begin
      chk("hold_during_busy", 32'({quotient, remainder, dbz, ovf}), 32'(hold_v));
    end
  end

  // ---------------- stimulus ----------------
  int edge_n[6] = '{-512, -511, -1, 0, 1, 511};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_flags{busy,done,dbz,ovf}", 32'({busy, done, dbz, ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(100, 7);
    run(-100, 7);
    run(100, -7);
    run(-100, -7);
    run(511, -16);
    run(-512, -1);
    run(37, 0);
    run(9, 3);

    // start pulsed mid-CALC with different operands must be ignored
    issue(100, 7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = DW'(5); divisor = VW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // reset during CALC: outputs clear at once, no done pulse afterwards
    issue(200, 3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_quotient", 32'(quotient), 32'd0);
    chk("midreset_remainder", 32'(remainder), 32'd0);
    chk("midreset_flags{busy,done,dbz,ovf}", 32'({busy, done, dbz, ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // boundary dividends against every divisor, back-to-back
    foreach (edge_n[i])
      for (int d = -16; d <= 15; d++) run(edge_n[i], d);

    repeat (2000) begin
      int n, d;
      n = int'($urandom_range(0, 1023)) - 512;
      d = int'($urandom_range(0, 31)) - 16;
      run(n, d);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
